// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module   : spi_reg_pkg
// Purpose  : Shared definitions for the SPI command/register stage: FSM state
//            encoding, fixed register addresses and the command read bit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam int ADDR_ID      = 0;
  localparam int ADDR_CTRL    = 1;
  localparam int ADDR_SCRATCH = 2;
  localparam int ADDR_STATUS  = 3;

  // Bit of the command header that selects read (1) or write (0).
  localparam int CMD_RD_BIT = 7;

endpackage

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module   : spi_reg_bank
// Purpose  : Register array behind the SPI command stage. Address 0 is the
//            read-only ID byte, address 3 is a saturating unexpected-byte
//            counter that any write clears, everything else is plain RW.
// Ports    : clk, rst        - clock, async active-high reset
//            we/waddr/wdata  - write port (one byte per cycle)
//            inc_status      - bump the STATUS counter (saturating)
//            raddr/rdata     - combinational read port
//            ctrl            - CTRL register contents
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              inc_status,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata,
  output logic [7:0]        ctrl
);

  localparam int NUM_REGS = 2**ADDR_W;

  // Entry 0 is never written; the ID value is substituted on the read port.
  logic [7:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i == ADDR_STATUS) begin
          // A clearing write takes priority over a same-cycle increment.
          if (we && (waddr == ADDR_W'(i))) begin
            regs[i] <= 8'h00;
          end else if (inc_status && (regs[i] != 8'hFF)) begin
            regs[i] <= regs[i] + 8'd1;
          end
        end else if (we && (waddr == ADDR_W'(i))) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  assign rdata = (raddr == ADDR_W'(ADDR_ID)) ? ID_VALUE : regs[raddr];
  assign ctrl  = regs[ADDR_CTRL];

endmodule

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// ============================================================================
// Module   : spi_reg_ctrl
// Purpose  : Command/register stage downstream of the SPI slave byte
//            interface. Decodes a one-byte command header per frame and then
//            performs auto-incrementing register writes or reads, supplying
//            the next transmit byte to the slave.
// Ports    : clk, rst            - clock, async active-high reset
//            cs                  - raw SPI chip-select (active-low, async)
//            rxd_data/rxd_flag   - received byte and its one-clk strobe
//            txd_data            - next byte for the slave to shift out
//            led_state, ctrl_reg - CTRL[0] and the full CTRL register
//            wr_strobe/wr_addr/wr_data - one-clk notification of each write
// Options  : SPI_REG_ECHO_EN - when defined, txd_data carries ID_VALUE in the
//            command phase and echoes the last written byte in the write phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5,
  parameter logic [7:0]  TXD_IDLE = 8'hC3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [7:0]        rxd_data,
  input  logic              rxd_flag,
  output logic [7:0]        txd_data,
  output logic              led_state,
  output logic [7:0]        ctrl_reg,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  // cs_q[1] is the synchronised level, cs_q[2] its previous value.
  // Resetting to 0 (frame active) means a reset while cs is held low does
  // not fabricate a frame start; the rest of that frame stays in IDLE and
  // the eventual rise is harmless there.
  logic [2:0] cs_q;
  logic       cs_fall;
  logic       cs_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q <= 3'b000;
    end else begin
      cs_q <= {cs_q[1:0], cs};
    end
  end

  assign cs_fall = cs_q[2] & ~cs_q[1];
  assign cs_rise = ~cs_q[2] & cs_q[1];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              bank_we;
  logic              inc_status;
  logic [7:0]        rd_data;
  logic [7:0]        txd_nxt;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    bank_we    = 1'b0;
    inc_status = 1'b0;
    case (state)
      ST_IDLE: begin
        inc_status = rxd_flag;
        if (cs_fall) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (rxd_flag) begin
          ptr_nxt   = rxd_data[ADDR_W-1:0];
          state_nxt = rxd_data[CMD_RD_BIT] ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (rxd_flag) begin
          bank_we = (ptr != ADDR_W'(ADDR_ID));
          ptr_nxt = ptr + 1'b1;
        end
      end
      ST_READ: begin
        if (rxd_flag) ptr_nxt = ptr + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A byte arriving with the cs rise is handled above before leaving.
    if (cs_rise) state_nxt = ST_IDLE;
  end

  // Transmit byte is chosen from the state being entered so it appears
  // exactly one clk after the triggering rxd_flag or cs edge.
  always_comb begin
    txd_nxt = TXD_IDLE;
    case (state_nxt)
      ST_READ:  txd_nxt = rd_data;
`ifdef SPI_REG_ECHO_EN
      ST_CMD:   txd_nxt = ID_VALUE;
      ST_WRITE: txd_nxt = ((state == ST_WRITE) && rxd_flag) ? rxd_data : txd_data;
`endif
      default:  txd_nxt = TXD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      txd_data  <= TXD_IDLE;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      txd_data  <= txd_nxt;
      wr_strobe <= bank_we;
      if (bank_we) begin
        wr_addr <= ptr;
        wr_data <= rxd_data;
      end
    end
  end

  // Read port looks at the next pointer so data lands with the update.
  spi_reg_bank #(
    .ADDR_W   (ADDR_W),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .we         (bank_we),
    .waddr      (ptr),
    .wdata      (rxd_data),
    .inc_status (inc_status),
    .raddr      (ptr_nxt),
    .rdata      (rd_data),
    .ctrl       (ctrl_reg)
  );

  assign led_state = ctrl_reg[0];

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// ============================================================================
// Module   : tb_spi_reg_ctrl
// Purpose  : Directed self-checking bench for spi_reg_ctrl.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic [7:0] rxd_data;
  logic       rxd_flag;
  wire  [7:0] txd_data;
  wire        led_state;
  wire  [7:0] ctrl_reg;
  wire        wr_strobe;
  wire  [3:0] wr_addr;
  wire  [7:0] wr_data;

`ifdef SPI_REG_ECHO_EN
  localparam logic [7:0] EXP_CMD = 8'hA5;
`else
  localparam logic [7:0] EXP_CMD = 8'hC3;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int s0;

  spi_reg_ctrl #(
    .ADDR_W   (4),
    .ID_VALUE (8'hA5),
    .TXD_IDLE (8'hC3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .rxd_data  (rxd_data),
    .rxd_flag  (rxd_flag),
    .txd_data  (txd_data),
    .led_state (led_state),
    .ctrl_reg  (ctrl_reg),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a byte for one clk; returns at the negedge after it was taken.
  task automatic send(input logic [7:0] b);
    rxd_data = b;
    rxd_flag = 1'b1;
    @(negedge clk);
    rxd_flag = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; rxd_data = 8'h00; rxd_flag = 1'b0;
    tick(3);
    check("rst_txd",    txd_data, 8'hC3);
    check("rst_led",    {7'd0, led_state}, 8'h00);
    check("rst_ctrl",   ctrl_reg, 8'h00);
    check("rst_strobe", {7'd0, wr_strobe}, 8'h00);
    check("rst_waddr",  {4'd0, wr_addr}, 8'h00);
    check("rst_wdata",  wr_data, 8'h00);
    rst = 1'b0;
    tick(2);

    // Read from ID then CTRL
    cs_low();
    check("cmd_txd", txd_data, EXP_CMD);
    send(8'h80);
    check("rd_id", txd_data, 8'hA5);
    send(8'h00);
    check("rd_ctrl0", txd_data, 8'h00);
    check("led0", {7'd0, led_state}, 8'h00);
    cs_high();
    check("idle_txd", txd_data, 8'hC3);

    // Single write to CTRL
    cs_low();
    s0 = strobe_cnt;
    send(8'h01);
    check("cmd_no_strobe", {7'd0, wr_strobe}, 8'h00);
    send(8'h01);
    check("wr1_strobe", {7'd0, wr_strobe}, 8'h01);
    check("wr1_addr",   {4'd0, wr_addr}, 8'h01);
    check("wr1_data",   wr_data, 8'h01);
    check("wr1_led",    {7'd0, led_state}, 8'h01);
    check("wr1_ctrl",   ctrl_reg, 8'h01);
    cs_high();
    check("wr1_idle_txd", txd_data, 8'hC3);
    check("wr1_nstrobe", 8'(strobe_cnt - s0), 8'd1);

    // Burst write across the wrap, ID write dropped
    cs_low();
    s0 = strobe_cnt;
    send(8'h0E);
    send(8'h11);
    check("bw_addr14", {4'd0, wr_addr}, 8'h0E);
    send(8'h22);
    check("bw_addr15", {4'd0, wr_addr}, 8'h0F);
    check("bw_data15", wr_data, 8'h22);
    send(8'h33);
    check("bw_id_nostrobe", {7'd0, wr_strobe}, 8'h00);
    cs_high();
    check("bw_nstrobe", 8'(strobe_cnt - s0), 8'd2);
    cs_low();
    send(8'h8E);
    check("br_r14", txd_data, 8'h11);
    send(8'h00);
    check("br_r15", txd_data, 8'h22);
    send(8'h00);
    check("br_wrap_id", txd_data, 8'hA5);
    cs_high();

    // Unexpected bytes counted in STATUS, write clears
    send(8'hAA); tick(2);
    send(8'hBB); tick(2);
    send(8'hCC); tick(2);
    cs_low();
    send(8'h83);
    check("status3", txd_data, 8'h03);
    cs_high();
    cs_low();
    send(8'h03);
    send(8'h55);
    cs_high();
    cs_low();
    send(8'h83);
    check("status_clr", txd_data, 8'h00);
    cs_high();

    // cs rise coincident with the second write byte
    cs_low();
    send(8'h04);
    send(8'h5A);
    cs = 1'b1;
    tick(2);
    send(8'h6B);
    check("coin_strobe", {7'd0, wr_strobe}, 8'h01);
    check("coin_addr",   {4'd0, wr_addr}, 8'h05);
    check("coin_data",   wr_data, 8'h6B);
    check("coin_txd",    txd_data, 8'hC3);
    tick(3);
    send(8'h77);
    check("coin_idle_nostrobe", {7'd0, wr_strobe}, 8'h00);
    cs_low();
    send(8'h84);
    check("coin_r4", txd_data, 8'h5A);
    send(8'h00);
    check("coin_r5", txd_data, 8'h6B);
    cs_high();
    cs_low();
    send(8'h83);
    check("coin_status", txd_data, 8'h01);
    cs_high();

    // Reset in the middle of a read burst
    cs_low();
    send(8'h01);
    send(8'hFF);
    cs_high();
    cs_low();
    send(8'h81);
    check("pre_rst_ctrl", txd_data, 8'hFF);
    send(8'h00);
    check("pre_rst_scratch", txd_data, 8'h00);
    rst = 1'b1;
    #1;
    check("mrst_txd",    txd_data, 8'hC3);
    check("mrst_ctrl",   ctrl_reg, 8'h00);
    check("mrst_led",    {7'd0, led_state}, 8'h00);
    check("mrst_strobe", {7'd0, wr_strobe}, 8'h00);
    check("mrst_waddr",  {4'd0, wr_addr}, 8'h00);
    check("mrst_wdata",  wr_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    send(8'h99);
    check("mrst_idle_txd", txd_data, 8'hC3);
    cs_high();
    cs_low();
    send(8'h83);
    check("mrst_status", txd_data, 8'h01);
    cs_high();
    cs_low();
    send(8'h81);
    check("mrst_rd_ctrl", txd_data, 8'h00);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
